// File: rtl/rs_br_pkg.sv
// Shared defaults and the per-entry record for the branch reservation station.
package rs_br_pkg;

    localparam int RS_BR_DEPTH = 8;
    localparam int RS_BR_TAG_W = 8;

    // Tags live outside the struct so the tag width can follow the TAG_W parameter.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] inst_num;
        logic [2:0]  func3;
        logic        jump;
        logic        branch;
        logic        taken;
        logic        hit;
        logic        rdy1;
        logic        rdy2;
        logic [31:0] op1;
        logic [31:0] op2;
    } rs_br_ent_t;

endpackage

// File: rtl/rs_branch_if.sv
// Dispatch, CDB, flush and issue signals of the branch reservation station.
interface rs_branch_if import rs_br_pkg::*; #(
    parameter int TAG_W = RS_BR_TAG_W
) ();
    logic             RS_br_start;
    logic             RS_br_Jump;
    logic             RS_br_Branch;
    logic             RS_br_IF_ID_taken;
    logic             RS_br_IF_ID_hit;
    logic [2:0]       RS_br_func3;
    logic [TAG_W-1:0] RS_br_phy_reg;
    logic [TAG_W-1:0] RS_br_operand1_phy;
    logic [TAG_W-1:0] RS_br_operand2_phy;
    logic [1:0]       RS_br_valid;
    logic [31:0]      RS_br_PC;
    logic [31:0]      RS_br_immediate;
    logic [31:0]      RS_br_inst_num;
    logic [31:0]      op1_data;
    logic [31:0]      op2_data;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_phy;
    logic [31:0]      cdb_data;
    logic             flush;
    logic             full;
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_pc;
    logic [31:0]      issue_imm;
    logic [31:0]      issue_inst_num;
    logic [31:0]      issue_op1;
    logic [31:0]      issue_op2;
    logic [2:0]       issue_func3;
    logic [TAG_W-1:0] issue_rd_phy;
    logic             issue_jump;
    logic             issue_branch;
    logic             issue_taken;
    logic             issue_hit;

    modport master (
        output RS_br_start, RS_br_Jump, RS_br_Branch, RS_br_IF_ID_taken, RS_br_IF_ID_hit,
               RS_br_func3, RS_br_phy_reg, RS_br_operand1_phy, RS_br_operand2_phy,
               RS_br_valid, RS_br_PC, RS_br_immediate, RS_br_inst_num, op1_data, op2_data,
               cdb_valid, cdb_phy, cdb_data, flush, issue_ready,
        input  full, issue_valid, issue_pc, issue_imm, issue_inst_num, issue_op1, issue_op2,
               issue_func3, issue_rd_phy, issue_jump, issue_branch, issue_taken, issue_hit
    );

    modport slave (
        input  RS_br_start, RS_br_Jump, RS_br_Branch, RS_br_IF_ID_taken, RS_br_IF_ID_hit,
               RS_br_func3, RS_br_phy_reg, RS_br_operand1_phy, RS_br_operand2_phy,
               RS_br_valid, RS_br_PC, RS_br_immediate, RS_br_inst_num, op1_data, op2_data,
               cdb_valid, cdb_phy, cdb_data, flush, issue_ready,
        output full, issue_valid, issue_pc, issue_imm, issue_inst_num, issue_op1, issue_op2,
               issue_func3, issue_rd_phy, issue_jump, issue_branch, issue_taken, issue_hit
    );
endinterface

// File: rtl/rs_br_select.sv
// Picks one ready entry: lowest index by default, smallest inst_num when
// RS_BR_OLDEST_FIRST_EN is defined.
module rs_br_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]       req_i,
`ifdef RS_BR_OLDEST_FIRST_EN
    input  logic [DEPTH-1:0][31:0] age_i,
`endif
    output logic [IDX_W-1:0]       idx_o,
    output logic                   found_o
);

`ifdef RS_BR_OLDEST_FIRST_EN
    logic [31:0] best;

    // Strict compare: on equal inst_num the lower index wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        best    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req_i[i] && (!found_o || age_i[i] < best)) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
                best    = age_i[i];
            end
        end
    end
`else
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/rs_branch.sv
// Branch/jump reservation station with CDB wakeup and a one-wide issue port.
// Optional RS_BR_OLDEST_FIRST_EN selects oldest-first issue instead of lowest index.
module rs_branch import rs_br_pkg::*; #(
    parameter int DEPTH = RS_BR_DEPTH,
    parameter int TAG_W = RS_BR_TAG_W
) (
    input  logic        clk,
    input  logic        reset,
    rs_branch_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]             busy_q, busy_d;
    rs_br_ent_t [DEPTH-1:0]       ent_q, ent_d;
    logic [DEPTH-1:0][TAG_W-1:0]  rd_q, rd_d, t1_q, t1_d, t2_q, t2_d;
    logic                         hold_q, hold_d;
    logic [IDX_W-1:0]             lock_q, lock_d;

    logic [DEPTH-1:0]             rdy_vec;
    logic [IDX_W-1:0]             sel_idx, iss_idx, free_idx;
    logic                         sel_found, iss_vld, iss_fire, alloc;
    rs_br_ent_t                   iss_e;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            rdy_vec[i] = busy_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
    end

`ifdef RS_BR_OLDEST_FIRST_EN
    logic [DEPTH-1:0][31:0] age;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) age[i] = ent_q[i].inst_num;
    end
`endif

    rs_br_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
        .req_i   (rdy_vec),
`ifdef RS_BR_OLDEST_FIRST_EN
        .age_i   (age),
`endif
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    // A stalled issue stays locked to its entry so a newly ready (lower or
    // older) entry cannot change issue_* under the consumer.
    assign iss_idx  = hold_q ? lock_q : sel_idx;
    assign iss_vld  = (hold_q | sel_found) & ~bus.flush;
    assign iss_fire = iss_vld & bus.issue_ready;
    assign bus.full = &busy_q;
    assign alloc    = bus.RS_br_start & ~bus.full & ~bus.flush;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!busy_q[i]) free_idx = IDX_W'(i);
    end

    always_comb begin
        busy_d = busy_q;
        ent_d  = ent_q;
        rd_d   = rd_q;
        t1_d   = t1_q;
        t2_d   = t2_q;
        hold_d = iss_vld & ~bus.issue_ready;
        lock_d = iss_idx;

        if (bus.cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && !ent_q[i].rdy1 && t1_q[i] == bus.cdb_phy) begin
                    ent_d[i].rdy1 = 1'b1;
                    ent_d[i].op1  = bus.cdb_data;
                end
                if (busy_q[i] && !ent_q[i].rdy2 && t2_q[i] == bus.cdb_phy) begin
                    ent_d[i].rdy2 = 1'b1;
                    ent_d[i].op2  = bus.cdb_data;
                end
            end
        end

        if (iss_fire) busy_d[iss_idx] = 1'b0;

        // free_idx comes from registered busy, so it never aliases the issuing entry.
        if (alloc) begin
            busy_d[free_idx]          = 1'b1;
            rd_d[free_idx]            = bus.RS_br_phy_reg;
            t1_d[free_idx]            = bus.RS_br_operand1_phy;
            t2_d[free_idx]            = bus.RS_br_operand2_phy;
            ent_d[free_idx].pc        = bus.RS_br_PC;
            ent_d[free_idx].imm       = bus.RS_br_immediate;
            ent_d[free_idx].inst_num  = bus.RS_br_inst_num;
            ent_d[free_idx].func3     = bus.RS_br_func3;
            ent_d[free_idx].jump      = bus.RS_br_Jump;
            ent_d[free_idx].branch    = bus.RS_br_Branch;
            ent_d[free_idx].taken     = bus.RS_br_IF_ID_taken;
            ent_d[free_idx].hit       = bus.RS_br_IF_ID_hit;
            ent_d[free_idx].rdy1      = bus.RS_br_valid[1] |
                                        (bus.cdb_valid && bus.cdb_phy == bus.RS_br_operand1_phy);
            ent_d[free_idx].rdy2      = bus.RS_br_valid[0] |
                                        (bus.cdb_valid && bus.cdb_phy == bus.RS_br_operand2_phy);
            ent_d[free_idx].op1       = bus.RS_br_valid[1] ? bus.op1_data : bus.cdb_data;
            ent_d[free_idx].op2       = bus.RS_br_valid[0] ? bus.op2_data : bus.cdb_data;
        end

        if (bus.flush) begin
            busy_d = '0;
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            ent_q  <= '0;
            rd_q   <= '0;
            t1_q   <= '0;
            t2_q   <= '0;
            hold_q <= 1'b0;
            lock_q <= '0;
        end else begin
            busy_q <= busy_d;
            ent_q  <= ent_d;
            rd_q   <= rd_d;
            t1_q   <= t1_d;
            t2_q   <= t2_d;
            hold_q <= hold_d;
            lock_q <= lock_d;
        end
    end

    assign iss_e              = iss_vld ? ent_q[iss_idx] : '0;
    assign bus.issue_valid    = iss_vld;
    assign bus.issue_pc       = iss_e.pc;
    assign bus.issue_imm      = iss_e.imm;
    assign bus.issue_inst_num = iss_e.inst_num;
    assign bus.issue_op1      = iss_e.op1;
    assign bus.issue_op2      = iss_e.op2;
    assign bus.issue_func3    = iss_e.func3;
    assign bus.issue_jump     = iss_e.jump;
    assign bus.issue_branch   = iss_e.branch;
    assign bus.issue_taken    = iss_e.taken;
    assign bus.issue_hit      = iss_e.hit;
    assign bus.issue_rd_phy   = iss_vld ? rd_q[iss_idx] : '0;

endmodule

// File: tb/tb_rs_branch.sv
// Directed bench for rs_branch; expected issues are queued at dispatch and
// compared as they leave the issue port.
module tb_rs_branch;
    import rs_br_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rs_branch_if #(.TAG_W(8)) bus ();
    rs_branch #(.DEPTH(8), .TAG_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] pc, op1, op2, inst;
    } exp_t;
    exp_t sb[$];

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Score a handshake in the current cycle, then advance one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("issue_pc",   bus.issue_pc,       e.pc);
                chk("issue_op1",  bus.issue_op1,      e.op1);
                chk("issue_op2",  bus.issue_op2,      e.op2);
                chk("issue_inst", bus.issue_inst_num, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] inst,
                        input logic [7:0] t1, input logic [7:0] t2, input logic [1:0] v,
                        input logic [31:0] o1, input logic [31:0] o2);
        bus.RS_br_start        = 1'b1;
        bus.RS_br_PC           = pc;
        bus.RS_br_inst_num     = inst;
        bus.RS_br_operand1_phy = t1;
        bus.RS_br_operand2_phy = t2;
        bus.RS_br_valid        = v;
        bus.op1_data           = o1;
        bus.op2_data           = o2;
        bus.RS_br_phy_reg      = 8'h3c;
        bus.RS_br_immediate    = pc + 32'd4;
        tick();
        bus.RS_br_start        = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.RS_br_start = 0; bus.RS_br_Jump = 0; bus.RS_br_Branch = 1;
        bus.RS_br_IF_ID_taken = 0; bus.RS_br_IF_ID_hit = 0; bus.RS_br_func3 = 3'd1;
        bus.RS_br_phy_reg = 0; bus.RS_br_operand1_phy = 0; bus.RS_br_operand2_phy = 0;
        bus.RS_br_valid = 0; bus.RS_br_PC = 0; bus.RS_br_immediate = 0;
        bus.RS_br_inst_num = 0; bus.op1_data = 0; bus.op2_data = 0;
        bus.cdb_valid = 0; bus.cdb_phy = 0; bus.cdb_data = 0;
        bus.flush = 0; bus.issue_ready = 0;
        tick(); tick();
        chk("rst_full",  32'(bus.full),        32'd0);
        chk("rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_pc",    bus.issue_pc,         32'd0);
        chk("rst_op1",   bus.issue_op1,        32'd0);
        reset = 1'b0;
        tick();

        // Ready at dispatch: issues the next cycle, then the entry is gone.
        bus.issue_ready = 1'b1;
        sb.push_back('{32'h100, 32'd5, 32'd5, 32'd1});
        disp(32'h100, 32'd1, 8'h01, 8'h02, 2'b11, 32'd5, 32'd5);
        #1 chk("r33_valid", 32'(bus.issue_valid), 32'd1);
        tick();
        #1 chk("r33_freed", 32'(bus.issue_valid), 32'd0);

        // Wakeup of src1 three cycles after dispatch.
        sb.push_back('{32'h200, 32'h77, 32'h33, 32'd2});
        disp(32'h200, 32'd2, 8'h12, 8'h00, 2'b01, 32'hdead, 32'h33);
        tick(); tick();
        chk("r34_wait", 32'(bus.issue_valid), 32'd0);
        bus.cdb_valid = 1; bus.cdb_phy = 8'h12; bus.cdb_data = 32'h77;
        tick();
        bus.cdb_valid = 0;
        #1 chk("r34_valid", 32'(bus.issue_valid), 32'd1);
        tick();

        // CDB hit on src1 in the allocation cycle, src2 wakes later.
        bus.cdb_valid = 1; bus.cdb_phy = 8'h21; bus.cdb_data = 32'hab;
        sb.push_back('{32'h280, 32'hab, 32'hcd, 32'd3});
        disp(32'h280, 32'd3, 8'h21, 8'h22, 2'b00, 32'h1, 32'h2);
        bus.cdb_valid = 0;
        tick();
        chk("r35_wait", 32'(bus.issue_valid), 32'd0);
        bus.cdb_valid = 1; bus.cdb_phy = 8'h22; bus.cdb_data = 32'hcd;
        tick();
        bus.cdb_valid = 0;
        tick();

        // Fill, overflow attempt, single drain, then empty.
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{32'h300 + 32'(i), 32'(i), 32'h50, 32'd10 + 32'(i)});
            disp(32'h300 + 32'(i), 32'd10 + 32'(i), 8'h0, 8'h0, 2'b11, 32'(i), 32'h50);
        end
        chk("r36_full", 32'(bus.full), 32'd1);
        chk("r36_hold", bus.issue_pc, 32'h300);
        disp(32'h3ff, 32'd99, 8'h0, 8'h0, 2'b11, 32'h9, 32'h9);
        chk("r36_full9", 32'(bus.full), 32'd1);
        chk("r36_hold2", bus.issue_pc, 32'h300);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        #1 chk("r36_notfull", 32'(bus.full), 32'd0);
        bus.issue_ready = 1'b1;
        repeat (8) tick();
        chk("r36_empty", 32'(bus.issue_valid), 32'd0);

        // Three entries woken together: selection order depends on the mode.
        bus.issue_ready = 1'b0;
        disp(32'h409, 32'd9, 8'h0, 8'h40, 2'b10, 32'h9, 32'h0);
        disp(32'h404, 32'd4, 8'h0, 8'h40, 2'b10, 32'h4, 32'h0);
        disp(32'h407, 32'd7, 8'h0, 8'h40, 2'b10, 32'h7, 32'h0);
`ifdef RS_BR_OLDEST_FIRST_EN
        sb.push_back('{32'h404, 32'h4, 32'he, 32'd4});
        sb.push_back('{32'h407, 32'h7, 32'he, 32'd7});
        sb.push_back('{32'h409, 32'h9, 32'he, 32'd9});
`else
        sb.push_back('{32'h409, 32'h9, 32'he, 32'd9});
        sb.push_back('{32'h404, 32'h4, 32'he, 32'd4});
        sb.push_back('{32'h407, 32'h7, 32'he, 32'd7});
`endif
        bus.cdb_valid = 1; bus.cdb_phy = 8'h40; bus.cdb_data = 32'he;
        tick();
        bus.cdb_valid = 0;
        bus.issue_ready = 1'b1;
        repeat (4) tick();

        // Same edge: B issues, A wakes, C allocates.
        bus.issue_ready = 1'b0;
        disp(32'h500, 32'd30, 8'h50, 8'h0, 2'b01, 32'h0, 32'h1);
        disp(32'h501, 32'd32, 8'h0, 8'h0, 2'b11, 32'h2, 32'h3);
        sb.push_back('{32'h501, 32'h2, 32'h3, 32'd32});
        sb.push_back('{32'h500, 32'h99, 32'h1, 32'd30});
        sb.push_back('{32'h502, 32'h4, 32'h5, 32'd31});
        bus.issue_ready = 1'b1;
        bus.cdb_valid = 1; bus.cdb_phy = 8'h50; bus.cdb_data = 32'h99;
        disp(32'h502, 32'd31, 8'h0, 8'h0, 2'b11, 32'h4, 32'h5);
        bus.cdb_valid = 0;
        repeat (3) tick();

        // Flush beats allocation and issue.
        bus.issue_ready = 1'b0;
        disp(32'h600, 32'd40, 8'h0, 8'h0, 2'b11, 32'h1, 32'h1);
        disp(32'h601, 32'd41, 8'h0, 8'h0, 2'b11, 32'h1, 32'h1);
        bus.flush = 1'b1; bus.issue_ready = 1'b1;
        #1 chk("r38_valid", 32'(bus.issue_valid), 32'd0);
        disp(32'h602, 32'd42, 8'h0, 8'h0, 2'b11, 32'h1, 32'h1);
        bus.flush = 1'b0;
        #1 chk("r38_full",   32'(bus.full),        32'd0);
        chk("r38_empty",     32'(bus.issue_valid), 32'd0);
        tick(); tick();

        // Reset mid-operation discards entries.
        bus.issue_ready = 1'b0;
        disp(32'h700, 32'd50, 8'h0, 8'h0, 2'b11, 32'h1, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 chk("rst2_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst2_pc",       bus.issue_pc,         32'd0);
        bus.issue_ready = 1'b1;
        tick(); tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rs_branch.md
RS_BRANCH -- requirements
Module: rs_branch

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of reservation entries, power of two from 2 to 16.
REQ-002 SHALL have parameter TAG_W, default 8: physical register tag width.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port RS_br_start, input, 1: dispatch request for one branch/jump op.
REQ-006 SHALL have ports RS_br_Jump, RS_br_Branch, RS_br_IF_ID_taken, RS_br_IF_ID_hit, input, 1 each: control and prediction flags.
REQ-007 SHALL have port RS_br_func3, input, 3: branch condition code.
REQ-008 SHALL have ports RS_br_phy_reg, RS_br_operand1_phy, RS_br_operand2_phy, input, TAG_W each: destination tag and source tags.
REQ-009 SHALL have port RS_br_valid, input, 2: bit1 = src1 ready, bit0 = src2 ready.
REQ-010 SHALL have ports RS_br_PC, RS_br_immediate, RS_br_inst_num, op1_data, op2_data, input, 32 each: PC, immediate, program-order number, and register-file source data.
REQ-011 SHALL have ports cdb_valid (input, 1), cdb_phy (input, TAG_W) and cdb_data (input, 32): result broadcast.
REQ-012 SHALL have port flush, input, 1: discard all entries.
REQ-013 SHALL have port full, output, 1: no free entry.
REQ-014 SHALL have ports issue_valid (output, 1) and issue_ready (input, 1): issue handshake.
REQ-015 SHALL have ports issue_pc, issue_imm, issue_inst_num, issue_op1, issue_op2 (output, 32 each); issue_func3 (output, 3); issue_rd_phy (output, TAG_W); and issue_jump, issue_branch, issue_taken, issue_hit (output, 1 each).

Function
REQ-016 SHALL hold, per entry: busy bit, all dispatch fields, and per source a ready bit, a tag and 32-bit data.
REQ-017 SHALL, on RS_br_start with full=0, write the lowest-index free entry at the clock edge; RS_br_start with full=1 SHALL be ignored.
REQ-018 SHALL capture op1_data/op2_data as source data when the matching RS_br_valid bit is 1.
REQ-019 SHALL, on cdb_valid, set ready and load cdb_data in every busy entry source whose tag equals cdb_phy and is not ready.
REQ-020 SHALL treat a CDB tag match on a source being allocated in the same cycle as ready, capturing cdb_data.
REQ-021 SHALL drive issue_valid combinationally when any busy entry has both sources ready; issue_* SHALL reflect the selected entry.
REQ-022 SHALL free the selected entry at the edge when issue_valid && issue_ready; issue_* SHALL hold stable while issue_valid=1 and issue_ready=0, unless flush is asserted.
REQ-023 SHALL give latency: alloc or wakeup at edge N, with issue_valid at the earliest in the cycle after N; ops are never issued in the cycle they arrive.
REQ-024 SHALL compute full = (busy count == DEPTH) from registered state; a same-cycle issue does not admit an allocation.
REQ-025 SHALL, on flush, clear all busy bits at the edge; flush SHALL take priority over allocation, wakeup and issue, and SHALL force issue_valid=0 in that cycle.
REQ-026 SHALL handle simultaneous allocation, wakeup and issue (different entries) in one edge without loss.

Reset
REQ-027 SHALL clear all busy bits and ready bits on reset; full, issue_valid and all issue_* outputs SHALL read 0.
REQ-028 SHALL give reset priority over flush and over all other inputs; asserting reset mid-operation SHALL discard in-flight entries.

Configuration
REQ-029 SHALL, with RS_BR_OLDEST_FIRST_EN defined, select among ready entries the one with the smallest RS_br_inst_num (32-bit unsigned compare, no wrap handling).
REQ-030 SHALL, without RS_BR_OLDEST_FIRST_EN, select the lowest-index ready entry.

Structure
REQ-031 SHALL place the entry struct, TAG_W default and DEPTH default in shared package rs_br_pkg.
REQ-032 SHALL implement ready-entry selection in one sub-module rs_br_select, which outputs index and found.

Verification
REQ-033 Dispatch, PC=0x100, valid=2'b11, op1=5, op2=5, issue_ready=1 -> issue_valid=1 next cycle with issue_op1=issue_op2=5 and issue_pc=0x100, then the entry is freed.
REQ-034 Dispatch, src1 tag=0x12, valid=2'b01; 3 cycles later cdb_valid, phy=0x12, data=0x77 -> issue_valid=1 the following cycle with issue_op1=0x77.
REQ-035 Dispatch with valid=2'b00 and CDB matching src1 in the same cycle; src2 wakes later -> issue_op1 equals the same-cycle CDB data.
REQ-036 Fill 8 entries with issue_ready=0 -> full=1; a 9th RS_br_start is ignored; one issue frees an entry -> full=0 next cycle.
REQ-037 Three ready entries with inst_num 9, 4 and 7 in indices 0-2 -> issue order 4,7,9 with RS_BR_OLDEST_FIRST_EN; 9,4,7 without.
REQ-038 Flush asserted together with RS_br_start and issue_ready=1 -> issue_valid=0 that cycle, no entry is freed or issued, and all entries are empty next cycle with full=0.
